// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller, FETCH/DECODE/EXEC/MEM/WB.
// Define MC_CTRL_SLT_EN to decode slt; otherwise funct 101010 is illegal.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             OF,
  output logic             pc_wr,
  output logic [1:0]       npc_sel,
  output logic             ir_wr,
  output logic             rf_wr,
  output logic [1:0]       reg_dst,
  output logic             alu_srcb,
  output logic [1:0]       ext_op,
  output logic [1:0]       alu_ctr,
  output logic             addi,
  output logic             dm_wr,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUBU  = 6'b100011;
`ifdef MC_CTRL_SLT_EN
  localparam logic [5:0] F_SLT   = 6'b101010;
`endif

  state_t           state_q, state_d;
  logic             of_q, of_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  logic is_r, i_addu, i_subu, i_slt, i_ori, i_lui;
  logic i_addi, i_lw, i_sw, i_beq, i_j, legal;

  // instruction decode from the IR fields
  always_comb begin
    is_r   = (opcode == OP_R);
    i_addu = is_r && (funct == F_ADDU);
    i_subu = is_r && (funct == F_SUBU);
`ifdef MC_CTRL_SLT_EN
    i_slt  = is_r && (funct == F_SLT);
`else
    i_slt  = 1'b0;
`endif
    i_ori  = (opcode == OP_ORI);
    i_lui  = (opcode == OP_LUI);
    i_addi = (opcode == OP_ADDI);
    i_lw   = (opcode == OP_LW);
    i_sw   = (opcode == OP_SW);
    i_beq  = (opcode == OP_BEQ);
    i_j    = (opcode == OP_J);
    legal  = i_addu | i_subu | i_slt | i_ori | i_lui |
             i_addi | i_lw | i_sw | i_beq | i_j;
  end

  // next state, control outputs and retire count
  always_comb begin
    state_d    = state_q;
    of_d       = of_q;
    retire     = 1'b0;
    pc_wr      = 1'b0;
    npc_sel    = 2'b00;
    ir_wr      = 1'b0;
    rf_wr      = 1'b0;
    reg_dst    = 2'b00;
    alu_srcb   = 1'b0;
    ext_op     = 2'b00;
    alu_ctr    = 2'b00;
    addi       = 1'b0;
    dm_wr      = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    if (rst_n && en) begin
      unique case (state_q)
        S_FETCH: begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          of_d    = 1'b0;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          unique case (1'b1)
            i_j: begin
              pc_wr   = 1'b1;
              npc_sel = 2'b10;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            !legal: begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
            default: state_d = S_EXEC;
          endcase
        end
        S_EXEC: begin
          // ALU result may move after EXEC, so keep OF for WB
          of_d = OF;
          unique case (1'b1)
            i_subu: alu_ctr = 2'b01;
`ifdef MC_CTRL_SLT_EN
            i_slt: alu_ctr = 2'b11;
`endif
            i_ori: begin
              alu_ctr  = 2'b10;
              alu_srcb = 1'b1;
            end
            i_lui: begin
              alu_srcb = 1'b1;
              ext_op   = 2'b10;
            end
            i_addi: begin
              alu_srcb = 1'b1;
              ext_op   = 2'b01;
              addi     = 1'b1;
            end
            i_lw, i_sw: begin
              alu_srcb = 1'b1;
              ext_op   = 2'b01;
            end
            i_beq: begin
              alu_ctr = 2'b01;
              npc_sel = 2'b01;
              pc_wr   = zero;
              retire  = 1'b1;
            end
            default: ;
          endcase
          if (i_beq) state_d = S_FETCH;
          else if (i_lw || i_sw) state_d = S_MEM;
          else state_d = S_WB;
        end
        S_MEM: begin
          if (i_sw) begin
            dm_wr   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else if (i_lw) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_WB: begin
          rf_wr      = 1'b1;
          retire     = 1'b1;
          mem_to_reg = i_lw;
          state_d    = S_FETCH;
          if (is_r) reg_dst = 2'b01;
          else if (i_addi && of_q) reg_dst = 2'b10;
        end
        default: state_d = S_FETCH;
      endcase
    end
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};
  end

  // state, OF flag and retire counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      of_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      of_q    <= of_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o   = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table vectors, hand sequences and random
// instructions against a per-instruction summary model.
module tb_mc_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_SLT   = 6'b101010;
`ifdef MC_CTRL_SLT_EN
  localparam bit SLT_ON = 1'b1;
`else
  localparam bit SLT_ON = 1'b0;
`endif

  logic        clk, rst_n, en, zero, OF;
  logic [5:0]  opcode, funct;
  logic        pc_wr, ir_wr, rf_wr, alu_srcb, addi;
  logic        dm_wr, mem_to_reg, illegal;
  logic [1:0]  npc_sel, reg_dst, ext_op, alu_ctr;
  logic [2:0]  state_o;
  logic [31:0] instr_cnt;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .opcode(opcode), .funct(funct),
    .zero(zero), .OF(OF),
    .pc_wr(pc_wr), .npc_sel(npc_sel),
    .ir_wr(ir_wr), .rf_wr(rf_wr),
    .reg_dst(reg_dst), .alu_srcb(alu_srcb),
    .ext_op(ext_op), .alu_ctr(alu_ctr),
    .addi(addi), .dm_wr(dm_wr),
    .mem_to_reg(mem_to_reg), .illegal(illegal),
    .state_o(state_o), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc, pc, ir, rf, dm, ill, ret;
    int rfs, dms, rdst, m2r, npc, exe;
  } res_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    bit         z;
    bit         of;
    res_t       e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  int   stall_bad, trace, held_g;
  res_t r;
  vec_t vec[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic res_t mk(int cyc, int pc, int rf, int dm, int ill,
                              int rdst, int m2r, int npc, int exe);
    res_t e;
    e.cyc = cyc; e.pc = pc; e.ir = 1; e.rf = rf; e.dm = dm;
    e.ill = ill; e.ret = ill ? 0 : 1;
    e.rfs = rf ? 16 : 0; e.dms = dm ? 8 : 0;
    e.rdst = rdst; e.m2r = m2r; e.npc = npc; e.exe = exe;
    return e;
  endfunction

  // summary model: what one instruction should do overall
  function automatic res_t model(logic [5:0] op, logic [5:0] fn,
                                 bit z, bit of);
    res_t e;
    bit r_ok, legal, wr;
    r_ok = (op == OP_R) &&
           (fn == F_ADDU || fn == F_SUBU || (SLT_ON && fn == F_SLT));
    legal = r_ok || op inside {OP_ORI, OP_LUI, OP_ADDI, OP_LW,
                               OP_SW, OP_BEQ, OP_J};
    wr = r_ok || op inside {OP_ORI, OP_LUI, OP_ADDI, OP_LW};
    e.ir  = 1;
    e.ill = legal ? 0 : 1;
    e.ret = legal ? 1 : 0;
    if (!legal || op == OP_J) e.cyc = 2;
    else if (op == OP_BEQ) e.cyc = 3;
    else if (op == OP_LW) e.cyc = 5;
    else e.cyc = 4;
    e.pc = 1;
    if (op == OP_J) e.pc = 2;
    if (op == OP_BEQ && z) e.pc = 2;
    e.rf  = wr ? 1 : 0;
    e.rfs = wr ? 16 : 0;
    e.dm  = (op == OP_SW) ? 1 : 0;
    e.dms = (op == OP_SW) ? 8 : 0;
    e.rdst = 0;
    if (r_ok) e.rdst = 1;
    else if (op == OP_ADDI && of) e.rdst = 2;
    e.m2r = (op == OP_LW) ? 1 : 0;
    e.npc = (op == OP_J) ? 2 : (op == OP_BEQ) ? 1 : 0;
    e.exe = 0;
    if (r_ok && fn == F_SUBU) e.exe = 'b010000;
    if (r_ok && fn == F_SLT) e.exe = 'b110000;
    case (op)
      OP_ORI:       e.exe = 'b101000;
      OP_LUI:       e.exe = 'b001100;
      OP_ADDI:      e.exe = 'b001011;
      OP_LW, OP_SW: e.exe = 'b001010;
      OP_BEQ:       e.exe = 'b010000;
      default: ;
    endcase
    return e;
  endfunction

  // smode: 0 none, 1 random stalls, 2 three stalls in EXEC
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input bit z, input bit of, input int smode);
    logic [2:0]  prev;
    logic [31:0] c0;
    bit stall, done;
    r = '{default: 0};
    stall_bad = 0; trace = 0; held_g = 0; done = 0;
    opcode = op; funct = fn; c0 = instr_cnt;
    for (int k = 0; k < 40 && !done; k++) begin
      prev = state_o;
      case (smode)
        1: stall = (k > 0) && ($urandom_range(0, 3) == 0);
        2: stall = (state_o == 3'd2) && (held_g < 3);
        default: stall = 1'b0;
      endcase
      if (stall) held_g++;
      en   = !stall;
      zero = (state_o == 3'd2) ? z : 1'($urandom);
      OF   = (state_o == 3'd2) ? of : !of;
      @(negedge clk);
      if (stall) begin
        if (pc_wr | ir_wr | rf_wr | dm_wr | illegal) stall_bad++;
      end else begin
        r.cyc++;
        trace = (trace << 3) | int'(state_o);
        r.pc  += int'(pc_wr);
        r.ir  += int'(ir_wr);
        r.rf  += int'(rf_wr);
        r.dm  += int'(dm_wr);
        r.ill += int'(illegal);
        if (rf_wr) begin
          r.rfs |= 1 << state_o;
          r.rdst = int'(reg_dst);
          r.m2r  = int'(mem_to_reg);
        end
        if (dm_wr) r.dms |= 1 << state_o;
        if (state_o == 3'd2)
          r.exe = int'({alu_ctr, alu_srcb, ext_op, addi});
        r.npc = int'(npc_sel);
      end
      @(posedge clk);
      #1;
      if (stall && state_o != prev) stall_bad++;
      if (!stall && state_o == 3'd0) done = 1'b1;
    end
    en = 1'b1;
    r.ret = int'(instr_cnt - c0);
    if (!done) chk("timeout", 0, 1);
  endtask

  task automatic chk_res(input string t, input res_t e);
    chk({t, " cycles"}, r.cyc, e.cyc);
    chk({t, " pc_wr"}, r.pc, e.pc);
    chk({t, " ir_wr"}, r.ir, e.ir);
    chk({t, " rf_wr"}, r.rf, e.rf);
    chk({t, " dm_wr"}, r.dm, e.dm);
    chk({t, " illegal"}, r.ill, e.ill);
    chk({t, " retire"}, r.ret, e.ret);
    chk({t, " rf_state"}, r.rfs, e.rfs);
    chk({t, " dm_state"}, r.dms, e.dms);
    chk({t, " reg_dst"}, r.rdst, e.rdst);
    chk({t, " mem_to_reg"}, r.m2r, e.m2r);
    chk({t, " npc_sel"}, r.npc, e.npc);
    chk({t, " exec_ctl"}, r.exe, e.exe);
    chk({t, " stall_quiet"}, stall_bad, 0);
    exp_cnt += e.ret;
    chk({t, " instr_cnt"}, int'(instr_cnt), exp_cnt);
  endtask

  initial begin
    logic [5:0] op, fn;
    bit z, of;
    int pick;

    vec.push_back('{OP_R, F_ADDU, 0, 0, mk(4, 1, 1, 0, 0, 1, 0, 0, 'b000000)});
    vec.push_back('{OP_R, F_SUBU, 0, 0, mk(4, 1, 1, 0, 0, 1, 0, 0, 'b010000)});
`ifdef MC_CTRL_SLT_EN
    vec.push_back('{OP_R, F_SLT, 0, 0, mk(4, 1, 1, 0, 0, 1, 0, 0, 'b110000)});
`else
    vec.push_back('{OP_R, F_SLT, 0, 0, mk(2, 1, 0, 0, 1, 0, 0, 0, 0)});
`endif
    vec.push_back('{OP_ORI, 0, 0, 0, mk(4, 1, 1, 0, 0, 0, 0, 0, 'b101000)});
    vec.push_back('{OP_LUI, 0, 0, 0, mk(4, 1, 1, 0, 0, 0, 0, 0, 'b001100)});
    vec.push_back('{OP_ADDI, 0, 0, 1, mk(4, 1, 1, 0, 0, 2, 0, 0, 'b001011)});
    vec.push_back('{OP_ADDI, 0, 0, 0, mk(4, 1, 1, 0, 0, 0, 0, 0, 'b001011)});
    vec.push_back('{OP_LW, 0, 0, 0, mk(5, 1, 1, 0, 0, 0, 1, 0, 'b001010)});
    vec.push_back('{OP_SW, 0, 0, 0, mk(4, 1, 0, 1, 0, 0, 0, 0, 'b001010)});
    vec.push_back('{OP_BEQ, 0, 1, 0, mk(3, 2, 0, 0, 0, 0, 0, 1, 'b010000)});
    vec.push_back('{OP_BEQ, 0, 0, 0, mk(3, 1, 0, 0, 0, 0, 0, 1, 'b010000)});
    vec.push_back('{OP_J, 0, 0, 0, mk(2, 2, 0, 0, 0, 0, 0, 2, 0)});
    vec.push_back('{6'b111111, 0, 0, 0, mk(2, 1, 0, 0, 1, 0, 0, 0, 0)});
    vec.push_back('{OP_R, 6'b000000, 0, 0, mk(2, 1, 0, 0, 1, 0, 0, 0, 0)});

    rst_n = 1'b0; en = 1'b1; opcode = OP_J; funct = '0;
    zero = 1'b0; OF = 1'b0;
    #12;
    chk("rst ctl", int'({pc_wr, npc_sel, ir_wr, rf_wr, reg_dst, alu_srcb,
                         ext_op, alu_ctr, addi, dm_wr, mem_to_reg, illegal}), 0);
    chk("rst state", int'(state_o), 0);
    chk("rst cnt", int'(instr_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; en = 1'b0;
    @(negedge clk);
    chk("en0 ir_wr", int'(ir_wr), 0);
    @(posedge clk);
    #1;
    chk("en0 state", int'(state_o), 0);

    run_instr(OP_R, F_ADDU, 0, 0, 0);
    chk("addu trace", trace, (1 << 6) | (2 << 3) | 4);
    chk_res("addu first", vec[0].e);

    foreach (vec[i]) begin
      run_instr(vec[i].op, vec[i].fn, vec[i].z, vec[i].of, 0);
      chk_res($sformatf("vec%0d", i), vec[i].e);
    end

    run_instr(OP_ORI, 0, 0, 0, 2);
    chk("ori stalls", held_g, 3);
    chk_res("ori stall", vec[3].e);

    opcode = OP_LW; funct = '0; en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    chk("lw in mem", int'(state_o), 3);
    rst_n = 1'b0;
    #1;
    chk("midrst state", int'(state_o), 0);
    chk("midrst rf_wr", int'(rf_wr), 0);
    chk("midrst cnt", int'(instr_cnt), 0);
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr(OP_R, F_ADDU, 0, 0, 0);
    chk_res("after rst", vec[0].e);

    for (int n = 0; n < 150; n++) begin
      pick = $urandom_range(0, 11);
      op = 6'($urandom);
      fn = 6'($urandom);
      z  = 1'($urandom);
      of = 1'($urandom);
      case (pick)
        0: begin op = OP_R; fn = F_ADDU; end
        1: begin op = OP_R; fn = F_SUBU; end
        2: begin op = OP_R; fn = F_SLT; end
        3: op = OP_R;
        4: op = OP_ORI;
        5: op = OP_LUI;
        6: op = OP_ADDI;
        7: op = OP_LW;
        8: op = OP_SW;
        9: op = OP_BEQ;
        10: op = OP_J;
        default: ;
      endcase
      run_instr(op, fn, z, of, 1);
      chk_res($sformatf("rnd%0d op%0h fn%0h", n, op, fn),
              model(op, fn, z, of));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the MIPS microsystem. It sits directly upstream of the ALU and drives its `alu_ctr` and `addi` inputs. It also sequences PC, IR, register-file and data-memory write enables across FETCH/DECODE/EXEC/MEM/WB. It consumes the ALU's `zero` and `OF` flags to resolve `beq` and the `addi` overflow write-back to `$30`, and keeps a retired-instruction counter for debug.

## Interface
Parameters:
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable; 0 freezes state, counter and all write enables.
- `opcode`  in  6  IR[31:26], stable from the cycle after FETCH.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag.
- `OF`  in  1  ALU overflow flag.
- `pc_wr`  out  1  PC write enable.
- `npc_sel`  out  2  next-PC select: 00 = PC+4, 01 = branch target, 10 = jump target.
- `ir_wr`  out  1  IR write enable.
- `rf_wr`  out  1  register-file write enable.
- `reg_dst`  out  2  destination select: 00 = rt, 01 = rd, 10 = `$30`.
- `alu_srcb`  out  1  ALU B operand: 0 = busB, 1 = extended immediate.
- `ext_op`  out  2  immediate extend: 00 = zero-extend, 01 = sign-extend, 10 = imm<<16.
- `alu_ctr`  out  2  ALU operation: 00 = add, 01 = sub, 10 = or, 11 = slt.
- `addi`  out  1  enables the ALU overflow check.
- `dm_wr`  out  1  data-memory write enable.
- `mem_to_reg`  out  1  write-back source: 0 = ALU register, 1 = DM register.
- `illegal`  out  1  one-cycle pulse on an unrecognised instruction.
- `state_o`  out  3  current state, for debug.
- `instr_cnt`  out  CNT_W  number of retired instructions.

## Operation
State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4.

Decoded instructions:
- R-type (opcode 000000): `addu` (funct 100001), `subu` (100011), `slt` (101010).
- I-type: `ori` 001101, `lui` 001111, `addi` 001000, `lw` 100011, `sw` 101011, `beq` 000100.
- J-type: `j` 000010.

Per-state behaviour:
- **FETCH**: `ir_wr` = 1, `pc_wr` = 1, `npc_sel` = 00. Next state DECODE.
- **DECODE**:
  - `j`: `pc_wr` = 1, `npc_sel` = 10; retire; next state FETCH.
  - Illegal instruction: `illegal` = 1; no write enables; not counted; next state FETCH.
  - All other instructions: next state EXEC.
- **EXEC**:
  - `addu`: `alu_ctr` = 00, `alu_srcb` = 0.
  - `subu`: `alu_ctr` = 01, `alu_srcb` = 0.
  - `slt`: `alu_ctr` = 11, `alu_srcb` = 0.
  - `ori`: `alu_ctr` = 10, `alu_srcb` = 1, `ext_op` = 00.
  - `lui`: `alu_ctr` = 00, `alu_srcb` = 1, `ext_op` = 10.
  - `addi`: `alu_ctr` = 00, `alu_srcb` = 1, `ext_op` = 01, `addi` = 1.
  - `lw`/`sw`: `alu_ctr` = 00, `alu_srcb` = 1, `ext_op` = 01.
  - `beq`: `alu_ctr` = 01, `alu_srcb` = 0, `npc_sel` = 01, `pc_wr` = `zero`; retire; next state FETCH. A taken and a not-taken branch retire identically.
  - Next state: MEM for `lw`/`sw`, WB otherwise.
- **MEM**:
  - `sw`: `dm_wr` = 1; retire; next state FETCH.
  - `lw`: next state WB.
- **WB**: `rf_wr` = 1; retire; next state FETCH.
  - `reg_dst`: 01 for R-type, 00 for I-type.
  - `mem_to_reg`: 1 for `lw`, 0 otherwise.
  - `addi` with `OF` latched in EXEC: `reg_dst` = 10, so the ALU's forced value 1 is written to `$30`.
- `OF` is sampled into an internal flag at the end of EXEC, because the ALU output may change after EXEC. The flag is cleared on the FETCH of the next instruction.
- `instr_cnt` increments by 1 on every retire and wraps to 0 from all-ones.

## Timing
- All outputs are combinational from the registered state, the latched OF flag, `opcode` and `funct`, gated by `en` and `rst_n`.
- Cycle counts per instruction:
  - `j`: 2 cycles.
  - `beq`: 3 cycles.
  - R-type, `ori`, `lui`, `addi`, `sw`: 4 cycles.
  - `lw`: 5 cycles.
- Reset values:
  - State FETCH, `state_o` = 0, `instr_cnt` = 0, OF flag = 0.
  - While `rst_n` = 0, every write enable, `illegal` and `addi` is 0; `npc_sel`, `reg_dst`, `ext_op` and `alu_ctr` are 00.
- First fetch: occurs in the first rising edge after `rst_n` deasserts, provided `en` = 1.
- Reset asserted mid-instruction: state returns to FETCH immediately; a partially executed instruction is not retired.
- `en` = 0:
  - All write enables are forced to 0; state, OF flag and counter hold.
  - When `en` returns to 1, execution resumes in the same state.

## Configuration
- `MC_CTRL_SLT_EN` defined: `slt` is decoded as above.
- `MC_CTRL_SLT_EN` undefined: funct 101010 is illegal (pulses `illegal`, returns to FETCH, not counted), and `alu_ctr` never drives 11.

## Test plan
- Reset, then `en` = 1 and `addu`: states 0→1→2→4→0; `rf_wr` = 1 only in WB with `reg_dst` = 01; `instr_cnt` = 1.
- `addi` with `OF` = 1 in EXEC: in WB, `rf_wr` = 1 and `reg_dst` = 10. Repeat with `OF` = 0: `reg_dst` = 00.
- `beq`, once with `zero` = 1 and once with `zero` = 0: EXEC has `pc_wr` = 1/0 respectively and `npc_sel` = 01; 3 cycles each; both retire.
- `lw` then `sw`: `lw` takes 5 cycles with `mem_to_reg` = 1 in WB; `sw` has `dm_wr` = 1 only in MEM and takes 4 cycles; `instr_cnt` += 2.
- `en` = 0 held for 3 cycles during EXEC of `ori`: `state_o` stays 2 and all enables are 0; after resume, WB completes with no duplicate write.
- Opcode 111111: `illegal` pulses in DECODE; next state FETCH; `instr_cnt` unchanged. Also assert `rst_n` = 0 mid-MEM of `lw`: `state_o` = 0 and `rf_wr` = 0 immediately.
